// File: rtl/cpu_mem_pkg.sv
// Shared types and widths for the CPU memory bus responders.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package cpu_mem_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

endpackage

// File: rtl/sp_ram_sync.sv
// Single-port synchronous RAM, one access per enabled edge, registered read port.
// Latency: read data appears on dout after the enabled edge; writes land at that edge.
// Backpressure: none; dout holds its value until the next enabled read.
module sp_ram_sync
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o
);

    // Storage is deliberately not reset: contents survive a bus reset.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] dout_q;

    // Write port: store data on an enabled write.
    always_ff @(posedge clock) begin
        if (en_i && we_i) begin
            mem_q[idx_i] <= din_i;
        end
    end

    // Read port: capture the addressed word on an enabled read, hold otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            dout_q <= '0;
        end else if (en_i && !we_i) begin
            dout_q <= mem_q[idx_i];
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/data_memory_responder.sv
// Word-addressed data memory answering a four-phase req/ack bus; build option DATA_MEM_ADDR_CHECK_EN adds err_o.
// Latency: ack_o rises WAIT_CYCLES+1 cycles after req_i is first sampled high.
// Backpressure: ack_o holds until req_i drops; a held req_i never triggers a second access.
module data_memory_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              ack_o,
    output logic              busy_o
`ifdef DATA_MEM_ADDR_CHECK_EN
    ,
    output logic              err_o
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mem_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ack_q;
    logic              busy_q;

    logic              in_idle;
    logic              acc_go;
    logic              acc_we;
    logic [IDX_W-1:0]  acc_idx;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_oob;
    logic              oob_now;
    logic              ram_en;
    logic [DATA_W-1:0] ram_dout;

    // With zero wait states the access happens at the accepting edge, so the
    // live bus inputs are used; otherwise the copies latched at acceptance.
    assign in_idle   = (state_q == IDLE);
    assign acc_we    = in_idle ? we_i : we_q;
    assign acc_idx   = in_idle ? addr_i[IDX_W-1:0] : idx_q;
    assign acc_wdata = in_idle ? wdata_i : wdata_q;

    // Access fires on the edge that enters DONE; reset on that edge discards it.
    assign acc_go = !reset &&
                    ((in_idle && req_i && (WAIT_CYCLES == 0)) ||
                     ((state_q == WAIT) && (cnt_q == CNT_ONE)));

`ifdef DATA_MEM_ADDR_CHECK_EN
    logic oob_q;
    logic err_q;
    logic rd_zero_q;

    assign oob_now = ({1'b0, addr_i} >= (ADDR_W + 1)'(DEPTH));
    assign acc_oob = in_idle ? oob_now : oob_q;
    assign err_o   = err_q;
    assign rdata_o = rd_zero_q ? '0 : ram_dout;
`else
    // Upper address bits are ignored: addresses alias modulo DEPTH.
    assign oob_now = 1'b0;
    assign acc_oob = 1'b0;
    assign rdata_o = ram_dout;
    if (IDX_W < ADDR_W) begin : g_alias
        logic unused_addr_hi;
        assign unused_addr_hi = ^addr_i[ADDR_W-1:IDX_W];
    end
`endif

    assign ram_en = acc_go && !acc_oob;

    sp_ram_sync #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clock  (clock),
        .reset  (reset),
        .en_i   (ram_en),
        .we_i   (acc_we),
        .idx_i  (acc_idx),
        .din_i  (acc_wdata),
        .dout_o (ram_dout)
    );

    // Handshake FSM: accept, count wait states, complete, wait for req to drop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
`ifdef DATA_MEM_ADDR_CHECK_EN
            oob_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_zero_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        we_q    <= we_i;
                        idx_q   <= addr_i[IDX_W-1:0];
                        wdata_q <= wdata_i;
                        busy_q  <= 1'b1;
`ifdef DATA_MEM_ADDR_CHECK_EN
                        oob_q   <= oob_now;
`endif
                        if (WAIT_CYCLES == 0) begin
                            state_q <= DONE;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (!req_i) begin
                        state_q <= IDLE;
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b0;
`ifdef DATA_MEM_ADDR_CHECK_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase

            // Completion bookkeeping shared by both DONE entry paths.
            if (acc_go) begin
                ack_q <= 1'b1;
`ifdef DATA_MEM_ADDR_CHECK_EN
                err_q <= acc_oob;
                if (!acc_we) begin
                    rd_zero_q <= acc_oob;
                end
`endif
            end
        end
    end

    assign ack_o  = ack_q;
    assign busy_o = busy_q;

endmodule
